// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : colour constants, display defaults and title table
// Rev 1.0 : initial release
// ============================================================================
package vga_pkg;

  typedef logic [11:0] rgb_t;

  localparam rgb_t BLACK = 12'h000;
  localparam rgb_t WHITE = 12'hFFF;
  localparam rgb_t GREY  = 12'h888;
  localparam rgb_t RED   = 12'hF00;
  localparam rgb_t GREEN = 12'h0F0;
  localparam rgb_t BLUE  = 12'h00F;
  localparam rgb_t CYAN  = 12'h0FF;

  localparam int H_VALID_DEF = 640;
  localparam int V_VALID_DEF = 480;
  localparam int TITLE_COUNT = 4;

  // Stage-1 result: colour is final unless glyph is set and the ROM bit is 1.
  typedef struct packed {
    logic valid;
    logic glyph;
    rgb_t colour;
  } stage1_t;

  function automatic logic [7:0] title_chars(input logic [3:0] t);
    case (t)
      4'd0:    return 8'd4;
      4'd1:    return 8'd3;
      4'd2:    return 8'd4;
      default: return 8'd2;
    endcase
  endfunction

  function automatic rgb_t title_bg(input logic [3:0] t);
    case (t)
      4'd0:    return RED;
      4'd1:    return CYAN;
      4'd2:    return GREEN;
      default: return BLUE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/title_glyph_rom.sv
`default_nettype none
// ============================================================================
// title_glyph_rom : title bitmap, 1-cycle registered bit read
// Rev 1.0 : initial release
// ============================================================================
module title_glyph_rom
  import vga_pkg::*;
#(
  parameter  int CHAR_W    = 32,
  parameter  int CHAR_H    = 32,
  parameter  int MAX_CHARS = 4,
  localparam int ROW_W     = $clog2(CHAR_H),
  localparam int COL_W     = $clog2(MAX_CHARS * CHAR_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       title,
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  output logic             rom_bit,
  output logic [7:0]       chars
);

  localparam int CW_B = $clog2(CHAR_W);
  localparam int AW   = 16;

  logic [COL_W-1:0] glyph;
  logic [CW_B-1:0]  gcol;
  logic             rom_bit_d;
  logic             rom_bit_q;

  assign glyph = col >> CW_B;
  assign gcol  = col[CW_B-1:0];

  // Procedural font: 4x4-pixel checkerboard whose phase flips per glyph and title.
  assign rom_bit_d = 1'((AW'(row) >> 2) + (AW'(gcol) >> 2) + AW'(glyph) + AW'(title));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rom_bit_q <= 1'b0;
    else     rom_bit_q <= rom_bit_d;
  end

  assign rom_bit = rom_bit_q;
  assign chars   = (title_chars(title) > 8'(MAX_CHARS)) ? 8'(MAX_CHARS) : title_chars(title);

endmodule
`default_nettype wire

// File: rtl/vga_pic_gen.sv
`default_nettype none
// ============================================================================
// vga_pic_gen : key-bar + scrolling title banner pixel generator, 2-cycle pipe
// Rev 1.0 : initial release
// ============================================================================
module vga_pic_gen
  import vga_pkg::*;
#(
  parameter int H_VALID     = H_VALID_DEF,
  parameter int V_VALID     = V_VALID_DEF,
  parameter int N_KEYS      = 7,
  parameter int SPLIT_NUM   = 7,
  parameter int SPLIT_DEN   = 10,
  parameter int CHAR_W      = 32,
  parameter int CHAR_H      = 32,
  parameter int MAX_CHARS   = 4,
  parameter int N_TITLES    = TITLE_COUNT,
  parameter int HOLD_FRAMES = 4,
  parameter int SCROLL_DIV  = 2
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic              pix_valid,
  input  logic              frame_start,
  input  logic [N_KEYS-1:0] status,
  input  logic [3:0]        title_sel,
  input  logic              scroll_en,
  output logic [11:0]       pix_data,
  output logic              pix_data_valid
);

  localparam int SPLIT    = H_VALID * SPLIT_NUM / SPLIT_DEN;
  localparam int MARGIN   = H_VALID / 8;
  localparam int KEY_W    = (SPLIT - MARGIN) / N_KEYS;
  localparam int REGION_W = H_VALID - SPLIT;
  localparam int OFF_W    = $clog2(REGION_W);
  localparam int C_W      = OFF_W + 1;
  localparam int PS_W     = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int ROW_W    = $clog2(CHAR_H);
  localparam int COL_W    = $clog2(MAX_CHARS * CHAR_W);

  localparam logic [9:0] SPLIT_X     = 10'(SPLIT);
  localparam logic [9:0] MARGIN_X    = 10'(MARGIN);
  localparam logic [9:0] KEYS_END_X  = 10'(MARGIN + N_KEYS * KEY_W);
  localparam logic [9:0] BANNER_ROWS = 10'((CHAR_H < V_VALID) ? CHAR_H : V_VALID);

  logic [N_KEYS-1:0][3:0] hold_q, hold_d;
  logic [3:0]             title_q, title_d, new_title;
  logic [OFF_W-1:0]       offset_q, offset_d;
  logic [PS_W-1:0]        presc_q, presc_d;
  stage1_t                s1_q, s1_d;
  logic [11:0]            pix_data_q, pix_data_d;
  logic                   pix_data_valid_q, pix_data_valid_d;

  logic [9:0]     rel_key;
  logic [C_W-1:0] rel_x, c_sum, c_pos;
  logic [15:0]    text_w;
  logic [7:0]     chars;
  logic           rom_bit;
  logic           key_press, key_held, key_sep;

  assign new_title = ({1'b0, title_sel} < 5'(N_TITLES)) ? title_sel : 4'd0;

  // Per-frame state; everything here moves only on frame_start.
  always_comb begin
    hold_d   = hold_q;
    title_d  = title_q;
    offset_d = offset_q;
    presc_d  = presc_q;
    if (frame_start) begin
      title_d = new_title;
      for (int k = 0; k < N_KEYS; k++) begin
        if (status[k])             hold_d[k] = 4'(HOLD_FRAMES);
        else if (hold_q[k] != 4'd0) hold_d[k] = hold_q[k] - 4'd1;
      end
      if (new_title != title_q) begin
        offset_d = '0;
        presc_d  = '0;
      end else if (scroll_en) begin
        if (presc_q == PS_W'(SCROLL_DIV - 1)) begin
          presc_d  = '0;
          offset_d = (offset_q == OFF_W'(REGION_W - 1)) ? '0 : offset_q + OFF_W'(1);
        end else begin
          presc_d = presc_q + PS_W'(1);
        end
      end
    end
  end

  assign rel_key = pix_x - MARGIN_X;
  assign rel_x   = C_W'(pix_x - SPLIT_X);
  assign c_sum   = rel_x + C_W'(offset_q);
  assign c_pos   = (c_sum >= C_W'(REGION_W)) ? c_sum - C_W'(REGION_W) : c_sum;
  assign text_w  = 16'(chars) * 16'(CHAR_W);

  title_glyph_rom #(
    .CHAR_W    (CHAR_W),
    .CHAR_H    (CHAR_H),
    .MAX_CHARS (MAX_CHARS)
  ) u_rom (
    .clk     (vga_clk),
    .rst     (sys_rst),
    .title   (title_q),
    .row     (pix_y[ROW_W-1:0]),
    .col     (COL_W'(c_pos)),
    .rom_bit (rom_bit),
    .chars   (chars)
  );

  // Stage 1: classify the pixel against pre-update counters and title.
  always_comb begin
    s1_d      = '0;
    key_press = 1'b0;
    key_held  = 1'b0;
    key_sep   = 1'b0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (rel_key >= 10'(k * KEY_W)) begin
        key_press = status[k];
        key_held  = (hold_q[k] != 4'd0);
        key_sep   = (k < N_KEYS - 1) && (rel_key == 10'((k + 1) * KEY_W - 1));
      end
    end
    if (pix_valid) begin
      s1_d.valid = 1'b1;
      if (pix_x < SPLIT_X) begin
        s1_d.colour = WHITE;
        if (pix_x >= MARGIN_X && pix_x < KEYS_END_X) begin
          if (key_sep || key_press) s1_d.colour = BLACK;
          else if (key_held)        s1_d.colour = GREY;
        end
      end else if (pix_y < BANNER_ROWS && 16'(c_pos) < text_w) begin
        s1_d.glyph  = 1'b1;
        s1_d.colour = title_bg(title_q);
      end else begin
        s1_d.colour = CYAN;
      end
    end
  end

  // Stage 2: glyph ink overrides the banner background.
  always_comb begin
    pix_data_d       = BLACK;
    pix_data_valid_d = s1_q.valid;
    if (s1_q.valid && !(s1_q.glyph && rom_bit)) pix_data_d = s1_q.colour;
  end

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold_q           <= '0;
      title_q          <= '0;
      offset_q         <= '0;
      presc_q          <= '0;
      s1_q             <= '0;
      pix_data_q       <= '0;
      pix_data_valid_q <= 1'b0;
    end else begin
      hold_q           <= hold_d;
      title_q          <= title_d;
      offset_q         <= offset_d;
      presc_q          <= presc_d;
      s1_q             <= s1_d;
      pix_data_q       <= pix_data_d;
      pix_data_valid_q <= pix_data_valid_d;
    end
  end

  assign pix_data       = pix_data_q;
  assign pix_data_valid = pix_data_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pic_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_pic_gen : randomized scoreboard bench for vga_pic_gen
// Rev 1.0 : initial release
// ============================================================================
module tb_vga_pic_gen;

  localparam int N_KEYS   = 7;
  localparam int H_VALID  = 640;
  localparam int SPLIT    = 448;
  localparam int MARGIN   = 80;
  localparam int KEY_W    = 52;
  localparam int REGION_W = 192;
  localparam int CHAR_W   = 32;
  localparam int CHAR_H   = 32;
  localparam int HOLD     = 4;
  localparam int SDIV     = 2;

  localparam logic [11:0] C_BLACK = 12'h000;
  localparam logic [11:0] C_WHITE = 12'hFFF;
  localparam logic [11:0] C_GREY  = 12'h888;
  localparam logic [11:0] C_RED   = 12'hF00;
  localparam logic [11:0] C_GREEN = 12'h0F0;
  localparam logic [11:0] C_BLUE  = 12'h00F;
  localparam logic [11:0] C_CYAN  = 12'h0FF;

  logic              vga_clk = 1'b0;
  logic              sys_rst;
  logic [9:0]        pix_x, pix_y;
  logic              pix_valid, frame_start;
  logic [N_KEYS-1:0] status;
  logic [3:0]        title_sel;
  logic              scroll_en;
  logic [11:0]       pix_data;
  logic              pix_data_valid;

  always #5 vga_clk = ~vga_clk;

  vga_pic_gen dut (
    .vga_clk        (vga_clk),
    .sys_rst        (sys_rst),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .pix_valid      (pix_valid),
    .frame_start    (frame_start),
    .status         (status),
    .title_sel      (title_sel),
    .scroll_en      (scroll_en),
    .pix_data       (pix_data),
    .pix_data_valid (pix_data_valid)
  );

  typedef struct {
    int          issue;
    logic [11:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  int m_hold[N_KEYS];
  int m_title, m_off, m_presc;

  always @(posedge vga_clk) cyc <= cyc + 1;

  function automatic int chars_of(int t);
    case (t)
      0:       return 4;
      1:       return 3;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [11:0] bg_of(int t);
    case (t)
      0:       return C_RED;
      1:       return C_CYAN;
      2:       return C_GREEN;
      default: return C_BLUE;
    endcase
  endfunction

  function automatic logic [11:0] model_pix(int x, int y, logic [N_KEYS-1:0] st);
    int k, pos, c, g, col;
    if (x < SPLIT) begin
      if (x < MARGIN || x >= MARGIN + N_KEYS * KEY_W) return C_WHITE;
      k   = (x - MARGIN) / KEY_W;
      pos = (x - MARGIN) % KEY_W;
      if (pos == KEY_W - 1 && k != N_KEYS - 1) return C_BLACK;
      if (st[k]) return C_BLACK;
      if (m_hold[k] != 0) return C_GREY;
      return C_WHITE;
    end
    c = (x - SPLIT + m_off) % REGION_W;
    if (y < CHAR_H && c < chars_of(m_title) * CHAR_W) begin
      g   = c / CHAR_W;
      col = c % CHAR_W;
      if (((y / 4) + (col / 4) + g + m_title) % 2 == 1) return C_BLACK;
      return bg_of(m_title);
    end
    return C_CYAN;
  endfunction

  task automatic model_frame(input logic [N_KEYS-1:0] st, input int tsel, input bit sen);
    int nt;
    nt = (tsel < 4) ? tsel : 0;
    for (int k = 0; k < N_KEYS; k++)
      m_hold[k] = st[k] ? HOLD : ((m_hold[k] > 0) ? m_hold[k] - 1 : 0);
    if (nt != m_title) begin
      m_off   = 0;
      m_presc = 0;
    end else if (sen) begin
      m_presc++;
      if (m_presc == SDIV) begin
        m_presc = 0;
        m_off   = (m_off + 1) % REGION_W;
      end
    end
    m_title = nt;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_KEYS; k++) m_hold[k] = 0;
    m_title = 0;
    m_off   = 0;
    m_presc = 0;
  endtask

  // Called just after a rising edge; presents one pixel for the next edge.
  task automatic drive(input bit fs, input bit v, input int x, input int y);
    exp_t e;
    frame_start = fs;
    pix_valid   = v;
    pix_x       = 10'(x);
    pix_y       = 10'(y);
    if (v) begin
      e.issue = cyc;
      e.data  = model_pix(x, y, status);
      q.push_back(e);
    end
    if (fs) model_frame(status, int'(title_sel), scroll_en);
    @(posedge vga_clk);
    #1;
  endtask

  function automatic int rand_x(bit banner);
    return banner ? int'($urandom_range(SPLIT, H_VALID - 1)) : int'($urandom_range(0, H_VALID - 1));
  endfunction

  function automatic int rand_y(bit banner);
    if (banner) return int'($urandom_range(0, CHAR_H - 1));
    return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 39)) : int'($urandom_range(0, 479));
  endfunction

  task automatic rand_frame(input int npix, input bit banner, input bit rnd_ctrl);
    if (rnd_ctrl) begin
      status    = N_KEYS'($urandom) & N_KEYS'($urandom);
      scroll_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) title_sel = 4'($urandom_range(0, 15));
    end
    drive(1'b1, $urandom_range(0, 9) != 0, rand_x(banner), rand_y(banner));
    for (int i = 0; i < npix; i++) begin
      if (rnd_ctrl && $urandom_range(0, 15) == 0) title_sel = 4'($urandom_range(0, 15));
      if (rnd_ctrl && $urandom_range(0, 7) == 0)  status = N_KEYS'($urandom);
      drive(1'b0, $urandom_range(0, 9) != 0, rand_x(banner), rand_y(banner));
    end
  endtask

  task automatic do_reset();
    #1;
    sys_rst = 1'b1;
    #1;
    checks++;
    if (pix_data !== 12'h000 || pix_data_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_midline got data=%h valid=%b expected data=000 valid=0", pix_data, pix_data_valid);
    end
    q.delete();
    model_reset();
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    @(posedge vga_clk);
    @(posedge vga_clk);
    #1;
    sys_rst = 1'b0;
  endtask

  // Monitor: pops one expectation per qualified output pixel.
  always @(negedge vga_clk) begin
    if (sys_rst === 1'b0) begin
      if (pix_data_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid cyc=%0d got data=%h with no pixel outstanding", cyc, pix_data);
        end else begin
          mon_e = q.pop_front();
          if (pix_data !== mon_e.data || cyc != mon_e.issue + 2) begin
            failures++;
            $display("FAIL pixel cyc=%0d got data=%h expected data=%h latency got=%0d expected=2",
                     cyc, pix_data, mon_e.data, cyc - mon_e.issue);
          end
        end
      end else begin
        checks++;
        if (pix_data !== 12'h000 || pix_data_valid !== 1'b0) begin
          failures++;
          $display("FAIL idle_output cyc=%0d got data=%h valid=%b expected data=000 valid=0",
                   cyc, pix_data, pix_data_valid);
        end
      end
    end
  end

  int xs[12] = '{140, 131, 132, 150, 183, 184, 60, 443, 444, 447, 0, 339};

  initial begin
    sys_rst     = 1'b1;
    pix_x       = '0;
    pix_y       = '0;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    status      = '0;
    title_sel   = '0;
    scroll_en   = 1'b0;
    model_reset();
    @(posedge vga_clk);
    #1;
    checks++;
    if (pix_data !== 12'h000 || pix_data_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got data=%h valid=%b expected data=000 valid=0", pix_data, pix_data_valid);
    end
    @(posedge vga_clk);
    #1;
    sys_rst = 1'b0;

    // Key bars with keys 0 and 2 pressed, title 2 static banner.
    status    = 7'b0000101;
    title_sel = 4'd2;
    scroll_en = 1'b0;
    drive(1'b1, 1'b0, 0, 0);
    foreach (xs[i]) drive(1'b0, 1'b1, xs[i], 100);
    repeat (40) drive(1'b0, 1'b1, rand_x(1'b1), rand_y(1'b1));
    drive(1'b0, 1'b1, 575, 31);
    drive(1'b0, 1'b1, 576, 0);
    drive(1'b0, 1'b1, 500, 32);

    // Key 3 pressed for one frame then released: decay highlight.
    status = 7'b0001000;
    drive(1'b1, 1'b1, 246, 100);
    drive(1'b0, 1'b1, 246, 200);
    status = '0;
    repeat (6) begin
      drive(1'b1, 1'b1, 246, 100);
      drive(1'b0, 1'b1, 246, 300);
      drive(1'b0, 1'b0, 0, 0);
    end

    // Out-of-range title falls back to title 0.
    title_sel = 4'd9;
    drive(1'b1, 1'b0, 0, 0);
    repeat (20) drive(1'b0, 1'b1, int'($urandom_range(448, 575)), rand_y(1'b1));

    // Long scroll run on title 2 to pass through the offset wrap.
    title_sel = 4'd2;
    scroll_en = 1'b1;
    status    = '0;
    repeat (400) rand_frame(3, 1'b1, 1'b0);
    title_sel = 4'd1;
    drive(1'b0, 1'b1, 600, 5);
    drive(1'b0, 1'b1, 470, 5);
    rand_frame(6, 1'b1, 1'b0);

    // Fully random traffic, reset mid-line, then more random traffic.
    repeat (150) rand_frame(20, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 200, 10);
    do_reset();
    repeat (80) rand_frame(20, 1'b0, 1'b1);

    pix_valid   = 1'b0;
    frame_start = 1'b0;
    repeat (5) begin
      @(posedge vga_clk);
      #1;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got outstanding=%0d expected outstanding=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
